ifetch_pipelined: RTL and testbench

Parametrised, decoupled instruction-fetch unit: the next-generation fetch stage of the single-cycle CPU. It issues sequential reads to a 1-cycle-latency instruction memory, buffers returned instructions with their PCs in a small prefetch FIFO, and hands them to decode over a valid/ready handshake. Branch and jump redirects from execute flush the FIFO and discard in-flight reads.

---
 rtl/ifetch_pkg.sv | 29 ++
 rtl/ifetch_fifo.sv | 58 +++++
 rtl/ifetch_pipelined.sv | 92 +++++++++
 tb/tb_ifetch_pipelined.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared fetch constants and redirect-target helpers.
// Helpers work on a 64-bit PC; callers truncate to their own PC width.
package ifetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int BR_OFF_W    = 16;
    localparam int J_FIELD_W   = 26;
    localparam int PC_MAX_W    = 64;

    localparam logic [PC_MAX_W-1:0] J_LOW_MASK = 64'h0000_0000_0FFF_FFFF;

    function automatic logic [PC_MAX_W-1:0] branch_target(
        input logic [PC_MAX_W-1:0] pc,
        input logic [BR_OFF_W-1:0] off
    );
        logic [PC_MAX_W-1:0] disp;
        disp = {{(PC_MAX_W-BR_OFF_W-2){off[BR_OFF_W-1]}}, off, 2'b00};
        return pc + disp;
    endfunction

    // Upper PC bits above the 28-bit jump region are kept from the redirecting PC.
    function automatic logic [PC_MAX_W-1:0] jump_target(
        input logic [PC_MAX_W-1:0]  pc,
        input logic [J_FIELD_W-1:0] field
    );
        return (pc & ~J_LOW_MASK) | {{(PC_MAX_W-J_FIELD_W-2){1'b0}}, field, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from registered storage.
// Zero-latency head; push is dropped only when full without a same-cycle pop.
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_pipelined.sv
// Decoupled fetch: sequential reads to a 1-cycle imem, prefetch FIFO to decode, redirect flush.
// Request-to-output 2 cycles; issue is credit-limited so FIFO plus in-flight never exceed DEPTH.
module ifetch_pipelined
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]          imem_rdata,
    input  logic                       redirect,
    input  logic                       is_jump,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic [BR_OFF_W-1:0]        branch_offset,
    input  logic [J_FIELD_W-1:0]       jump_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]        fetch_pc;
    logic                     inflight;
    logic [ADDR_W-1:0]        inflight_pc;
    logic                     inflight_kill;
    logic                     pop;
    logic                     push;
    logic [CNT_W:0]           occupancy;
    logic [ADDR_W-1:0]        target;
    logic [ADDR_W+DATA_W-1:0] head;

    assign pop       = out_valid && out_ready;
    assign out_valid = (count != '0);
    assign imem_addr = fetch_pc;
    assign {out_pc, out_instr} = head;

    // Credits: entries held plus the read in flight, less the one leaving this cycle.
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign imem_req  = reset_n && !redirect && (occupancy < (CNT_W+1)'(DEPTH));
    assign push      = inflight && !inflight_kill && !redirect;

    always_comb begin
        target = ADDR_W'(branch_target(PC_MAX_W'(redirect_pc), branch_offset));
        if (is_jump) begin
            target = ADDR_W'(jump_target(PC_MAX_W'(redirect_pc), jump_addr));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            inflight_pc   <= '0;
            inflight_kill <= 1'b0;
        end else if (redirect) begin
            fetch_pc      <= target;
            inflight      <= 1'b0;
            inflight_kill <= inflight;
        end else if (imem_req) begin
            inflight_pc   <= fetch_pc;
            fetch_pc      <= fetch_pc + ADDR_W'(INSTR_BYTES);
            inflight      <= 1'b1;
            inflight_kill <= 1'b0;
        end else begin
            inflight      <= 1'b0;
            inflight_kill <= 1'b0;
        end
    end

    ifetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop && !redirect),
        .flush   (redirect),
        .din     ({inflight_pc, imem_rdata}),
        .head    (head),
        .count   (count)
    );

endmodule

// File: tb/tb_ifetch_pipelined.sv
// Directed stimulus with an expected-PC scoreboard drained by a negedge monitor.
module tb_ifetch_pipelined;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata = '0;
    logic          redirect = 1'b0;
    logic          is_jump = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [15:0]   branch_offset = '0;
    logic [25:0]   jump_addr = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [CW-1:0] count;

    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] mon_e;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    ifetch_pipelined #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .is_jump       (is_jump),
        .redirect_pc   (redirect_pc),
        .branch_offset (branch_offset),
        .jump_addr     (jump_addr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .count         (count)
    );

    // Memory image: word i holds 0x1000 + i.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return 32'h1000 + {2'b00, a[AW-1:2]};
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got pc %0h, required no transfer", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pc", out_pc, mon_e);
                chk("out_instr", out_instr, mem_word(mon_e));
            end
        end
    end

    task automatic expect_seq(input logic [AW-1:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + AW'(4 * i));
    endtask

    task automatic consume(input int n);
        int left = n;
        int cyc  = 0;
        while (left > 0 && cyc < 100) begin
            @(posedge clk); #1 out_ready = 1'b1;
            @(negedge clk);
            if (out_valid) left--;
            cyc++;
        end
        @(posedge clk); #1 out_ready = 1'b0;
        chk("consume_remaining", left, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_pc", out_pc, 0);

        // Streaming start-up and 1/cycle throughput
        @(posedge clk); #1 reset_n = 1'b1; out_ready = 1'b1;
        expect_seq(32'h0, 8);
        @(negedge clk);
        chk("c0_imem_req", imem_req, 1);
        chk("c0_imem_addr", imem_addr, 0);
        chk("c0_out_valid", out_valid, 0);
        @(negedge clk);
        chk("c1_out_valid", out_valid, 0);
        for (int c = 2; c < 10; c++) begin
            @(negedge clk);
            chk("stream_valid", out_valid, 1);
        end

        // Backpressure: saturate, then resume contiguously
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_count", count, DEPTH);
        chk("bp_imem_req", imem_req, 0);
        chk("bp_out_pc", out_pc, 32'h20);
        expect_seq(32'h20, 6);
        consume(6);
        repeat (4) @(posedge clk);

        // Branch redirect: 0x40 + (-4 << 2) = 0x30
        #1 redirect = 1'b1; is_jump = 1'b0; redirect_pc = 32'h40; branch_offset = 16'hFFFC;
        expect_seq(32'h30, 2);
        @(negedge clk);
        chk("br_t_imem_req", imem_req, 0);
        @(posedge clk); #1 redirect = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("br_t1_count", count, 0);
        chk("br_t1_out_valid", out_valid, 0);
        chk("br_t1_imem_req", imem_req, 1);
        chk("br_t1_imem_addr", imem_addr, 32'h30);
        @(negedge clk);
        chk("br_t2_out_valid", out_valid, 0);
        @(negedge clk);
        chk("br_t3_out_valid", out_valid, 1);
        chk("br_t3_out_pc", out_pc, 32'h30);
        @(negedge clk);

        // Jump coincident with a pop and a returning response
        @(posedge clk); #1 redirect = 1'b1; is_jump = 1'b1;
        redirect_pc = 32'hA000_0010; jump_addr = 26'h000_0100;
        @(negedge clk);
        chk("jp_t_count", count, 1);
        chk("jp_t_out_pc", out_pc, 32'h38);
        chk("jp_t_imem_req", imem_req, 0);
        expect_seq(32'hA000_0400, 3);
        @(posedge clk); #1 redirect = 1'b0; is_jump = 1'b0;
        @(negedge clk);
        chk("jp_t1_count", count, 0);
        chk("jp_t1_out_valid", out_valid, 0);
        chk("jp_t1_imem_addr", imem_addr, 32'hA000_0400);
        @(negedge clk);
        chk("jp_t2_out_valid", out_valid, 0);
        @(negedge clk);
        chk("jp_t3_out_valid", out_valid, 1);
        chk("jp_t3_out_pc", out_pc, 32'hA000_0400);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);

        // Half-cycle reset pulse with a full FIFO
        @(negedge clk);
        chk("pre_rst_count", count, DEPTH);
        @(posedge clk); #2 reset_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_imem_req", imem_req, 0);
        #4 reset_n = 1'b1;
        #1;
        chk("rel_imem_req", imem_req, 1);
        chk("rel_imem_addr", imem_addr, 0);
        expect_seq(32'h0, 3);
        consume(3);

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
